// File: rtl/mem_bus_router.sv
// rtl/mem_bus_router.sv - PicoRV32 memory router: RAM/MMIO decode, slave handshake, error response.
// Optional slave-timeout error path compiled in with MEM_BUS_TIMEOUT_EN.
module mem_bus_router #(
  parameter int unsigned RAM_BYTES      = 8192,
  parameter logic [31:0] MMIO_BASE      = 32'h4000_0000,
  parameter int unsigned MMIO_BYTES     = 256,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_mem_valid,
  input  logic        cpu_mem_instr,
  output logic        cpu_mem_ready,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [3:0]  cpu_mem_wstrb,
  output logic [31:0] cpu_mem_rdata,
  output logic        ram_mem_valid,
  output logic        ram_mem_instr,
  output logic [31:0] ram_mem_addr,
  output logic [31:0] ram_mem_wdata,
  output logic [3:0]  ram_mem_wstrb,
  input  logic        ram_mem_ready,
  input  logic [31:0] ram_mem_rdata,
  output logic        mmio_mem_valid,
  output logic        mmio_mem_instr,
  output logic [31:0] mmio_mem_addr,
  output logic [31:0] mmio_mem_wdata,
  output logic [3:0]  mmio_mem_wstrb,
  input  logic        mmio_mem_ready,
  input  logic [31:0] mmio_mem_rdata,
  output logic        bus_err,
  output logic [31:0] bus_err_addr
);

  localparam logic [31:0] RAM_LIMIT = 32'(RAM_BYTES);
  localparam logic [31:0] MMIO_MASK = 32'(MMIO_BYTES - 1);

  if (((RAM_BYTES & (RAM_BYTES - 1)) != 0) || ((MMIO_BYTES & (MMIO_BYTES - 1)) != 0) ||
      ((MMIO_BASE & MMIO_MASK) != 32'd0) || (TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535))
  begin : g_bad_params
    $error("mem_bus_router: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, RAM_WAIT, MMIO_WAIT, RESP} state_t;

  state_t      state;
  logic        err_pend;
  logic [31:0] req_addr;
  logic        sel_ready;
  logic [31:0] sel_rdata;
  logic        ram_hit;
  logic        mmio_hit;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt;
`endif

  // Full 32-bit compares so high-address aliases fall through to the error path.
  assign ram_hit  = cpu_mem_addr < RAM_LIMIT;
  assign mmio_hit = (cpu_mem_addr & ~MMIO_MASK) == MMIO_BASE;

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = 32'd0;
    if (state == RAM_WAIT) begin
      sel_ready = ram_mem_ready;
      sel_rdata = ram_mem_rdata;
    end else if (state == MMIO_WAIT) begin
      sel_ready = mmio_mem_ready;
      sel_rdata = mmio_mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      err_pend       <= 1'b0;
      req_addr       <= 32'd0;
      cpu_mem_ready  <= 1'b0;
      cpu_mem_rdata  <= 32'd0;
      ram_mem_valid  <= 1'b0;
      ram_mem_instr  <= 1'b0;
      ram_mem_addr   <= 32'd0;
      ram_mem_wdata  <= 32'd0;
      ram_mem_wstrb  <= 4'd0;
      mmio_mem_valid <= 1'b0;
      mmio_mem_instr <= 1'b0;
      mmio_mem_addr  <= 32'd0;
      mmio_mem_wdata <= 32'd0;
      mmio_mem_wstrb <= 4'd0;
      bus_err        <= 1'b0;
      bus_err_addr   <= 32'd0;
`ifdef MEM_BUS_TIMEOUT_EN
      wait_cnt       <= 16'd0;
`endif
    end else begin
      cpu_mem_ready <= 1'b0;
      bus_err       <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_mem_valid && !cpu_mem_ready) begin
            req_addr <= cpu_mem_addr;
`ifdef MEM_BUS_TIMEOUT_EN
            wait_cnt <= 16'd0;
`endif
            if (ram_hit) begin
              ram_mem_valid <= 1'b1;
              ram_mem_instr <= cpu_mem_instr;
              ram_mem_addr  <= cpu_mem_addr;
              ram_mem_wdata <= cpu_mem_wdata;
              ram_mem_wstrb <= cpu_mem_wstrb;
              state         <= RAM_WAIT;
            end else if (mmio_hit) begin
              mmio_mem_valid <= 1'b1;
              mmio_mem_instr <= cpu_mem_instr;
              mmio_mem_addr  <= cpu_mem_addr & MMIO_MASK;
              mmio_mem_wdata <= cpu_mem_wdata;
              mmio_mem_wstrb <= cpu_mem_wstrb;
              state          <= MMIO_WAIT;
            end else begin
              // Unmapped: spend one cycle so the error answer has the same register depth.
              err_pend <= 1'b1;
              state    <= RESP;
            end
          end
        end
        RAM_WAIT, MMIO_WAIT: begin
          if (sel_ready) begin
            ram_mem_valid  <= 1'b0;
            ram_mem_wstrb  <= 4'd0;
            mmio_mem_valid <= 1'b0;
            mmio_mem_wstrb <= 4'd0;
            cpu_mem_rdata  <= sel_rdata;
            cpu_mem_ready  <= 1'b1;
            state          <= RESP;
          end
`ifdef MEM_BUS_TIMEOUT_EN
          else if (wait_cnt == TO_LAST) begin
            ram_mem_valid  <= 1'b0;
            ram_mem_wstrb  <= 4'd0;
            mmio_mem_valid <= 1'b0;
            mmio_mem_wstrb <= 4'd0;
            cpu_mem_rdata  <= ERR_RDATA;
            cpu_mem_ready  <= 1'b1;
            bus_err        <= 1'b1;
            bus_err_addr   <= req_addr;
            state          <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end
        RESP: begin
          if (err_pend) begin
            err_pend      <= 1'b0;
            cpu_mem_rdata <= ERR_RDATA;
            cpu_mem_ready <= 1'b1;
            bus_err       <= 1'b1;
            bus_err_addr  <= req_addr;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_router.sv
// tb/tb_mem_bus_router.sv - self-checking bench for mem_bus_router with RAM/MMIO slave models.
module tb_mem_bus_router;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cpu_mem_valid = 1'b0, cpu_mem_instr = 1'b0, cpu_mem_ready;
  logic [31:0] cpu_mem_addr = '0, cpu_mem_wdata = '0, cpu_mem_rdata;
  logic [3:0]  cpu_mem_wstrb = '0;
  logic        ram_mem_valid, ram_mem_instr, ram_mem_ready = 1'b0;
  logic [31:0] ram_mem_addr, ram_mem_wdata, ram_mem_rdata = '0;
  logic [3:0]  ram_mem_wstrb;
  logic        mmio_mem_valid, mmio_mem_instr, mmio_mem_ready = 1'b0;
  logic [31:0] mmio_mem_addr, mmio_mem_wdata, mmio_mem_rdata = '0;
  logic [3:0]  mmio_mem_wstrb;
  logic        bus_err;
  logic [31:0] bus_err_addr;

  always #5 clk = ~clk;

  mem_bus_router #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_mem_valid(cpu_mem_valid), .cpu_mem_instr(cpu_mem_instr), .cpu_mem_ready(cpu_mem_ready),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_wstrb(cpu_mem_wstrb),
    .cpu_mem_rdata(cpu_mem_rdata),
    .ram_mem_valid(ram_mem_valid), .ram_mem_instr(ram_mem_instr), .ram_mem_addr(ram_mem_addr),
    .ram_mem_wdata(ram_mem_wdata), .ram_mem_wstrb(ram_mem_wstrb), .ram_mem_ready(ram_mem_ready),
    .ram_mem_rdata(ram_mem_rdata),
    .mmio_mem_valid(mmio_mem_valid), .mmio_mem_instr(mmio_mem_instr), .mmio_mem_addr(mmio_mem_addr),
    .mmio_mem_wdata(mmio_mem_wdata), .mmio_mem_wstrb(mmio_mem_wstrb), .mmio_mem_ready(mmio_mem_ready),
    .mmio_mem_rdata(mmio_mem_rdata),
    .bus_err(bus_err), .bus_err_addr(bus_err_addr)
  );

  int checks = 0, failures = 0;
  logic [31:0] ram_mem [0:2047];
  logic [31:0] ref_ram [0:2047];
  logic [31:0] mmio_regs [0:63];
  logic [31:0] ref_mmio [0:63];
  int ram_lat = 0, mmio_lat = 0, ram_cnt = 0, mmio_cnt = 0;
  bit ram_stall = 1'b0;
  int ram_vcyc = 0, mmio_vcyc = 0, bus_viol = 0;
  logic [31:0] seen_addr = '0, seen_wdata = '0;
  logic [3:0]  seen_wstrb = '0;
  logic        seen_instr = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] st);
    merge = old;
    for (int b = 0; b < 4; b++) if (st[b]) merge[8*b +: 8] = wd[8*b +: 8];
  endfunction

  // 1 = RAM window, 2 = MMIO window, 0 = unmapped
  function automatic int kind_of(input logic [31:0] a);
    if (a < 32'd8192) return 1;
    if (a >= 32'h4000_0000 && a < 32'h4000_0100) return 2;
    return 0;
  endfunction

  initial forever begin
    @(negedge clk);
    if (ram_mem_ready) ram_mem_ready = 1'b0;
    else if (ram_mem_valid && !ram_stall) begin
      if (ram_cnt == ram_lat) begin
        ram_mem_rdata = ram_mem[ram_mem_addr[12:2]];
        ram_mem[ram_mem_addr[12:2]] = merge(ram_mem_rdata, ram_mem_wdata, ram_mem_wstrb);
        seen_addr = ram_mem_addr; seen_wdata = ram_mem_wdata;
        seen_wstrb = ram_mem_wstrb; seen_instr = ram_mem_instr;
        ram_mem_ready = 1'b1; ram_cnt = 0;
      end else ram_cnt++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (mmio_mem_ready) mmio_mem_ready = 1'b0;
    else if (mmio_mem_valid) begin
      if (mmio_cnt == mmio_lat) begin
        mmio_mem_rdata = mmio_regs[mmio_mem_addr[7:2]];
        mmio_regs[mmio_mem_addr[7:2]] = merge(mmio_mem_rdata, mmio_mem_wdata, mmio_mem_wstrb);
        seen_addr = mmio_mem_addr; seen_wdata = mmio_mem_wdata;
        seen_wstrb = mmio_mem_wstrb; seen_instr = mmio_mem_instr;
        mmio_mem_ready = 1'b1; mmio_cnt = 0;
      end else mmio_cnt++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (ram_mem_valid) ram_vcyc++;
    if (mmio_mem_valid) mmio_vcyc++;
    if ((!ram_mem_valid && ram_mem_wstrb != 0) || (!mmio_mem_valid && mmio_mem_wstrb != 0) ||
        (ram_mem_valid && mmio_mem_valid)) bus_viol++;
  end

  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                        input logic ins, input bit hold,
                        output logic [31:0] rd, output logic er, output int cyc);
    ram_vcyc = 0; mmio_vcyc = 0; ram_cnt = 0; mmio_cnt = 0;
    @(negedge clk);
    cpu_mem_valid = 1'b1; cpu_mem_addr = a; cpu_mem_wdata = wd;
    cpu_mem_wstrb = st; cpu_mem_instr = ins;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!cpu_mem_ready && cyc < 1000);
    check($sformatf("ready_seen@%h", a), 32'(cpu_mem_ready), 32'd1);
    rd = cpu_mem_rdata; er = bus_err;
    if (!hold) begin cpu_mem_valid = 1'b0; cpu_mem_wstrb = 4'd0; end
    @(negedge clk);
    check($sformatf("ready_one_cycle@%h", a), 32'(cpu_mem_ready), 32'd0);
    check($sformatf("err_one_cycle@%h", a), 32'(bus_err), 32'd0);
    check($sformatf("no_dup_request@%h", a), 32'(ram_mem_valid | mmio_mem_valid), 32'd0);
    cpu_mem_valid = 1'b0; cpu_mem_wstrb = 4'd0;
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                     input logic ins, input bit hold, input int lat);
    int k, cyc;
    logic [31:0] exp_rd, rd;
    logic er;
    k = kind_of(a);
    ram_lat = lat; mmio_lat = lat;
    exp_rd = ERR;
    if (k == 1) begin
      exp_rd = ref_ram[a[12:2]]; ref_ram[a[12:2]] = merge(exp_rd, wd, st);
    end else if (k == 2) begin
      exp_rd = ref_mmio[a[7:2]]; ref_mmio[a[7:2]] = merge(exp_rd, wd, st);
    end
    access(a, wd, st, ins, hold, rd, er, cyc);
    check($sformatf("rdata@%h", a), rd, exp_rd);
    check($sformatf("bus_err@%h", a), 32'(er), 32'(k == 0));
    check($sformatf("latency@%h", a), cyc, (k == 0) ? 2 : 2 + lat);
    check($sformatf("ram_valid_cycles@%h", a), ram_vcyc, (k == 1) ? lat + 1 : 0);
    check($sformatf("mmio_valid_cycles@%h", a), mmio_vcyc, (k == 2) ? lat + 1 : 0);
    if (k == 0) check($sformatf("bus_err_addr@%h", a), bus_err_addr, a);
    else begin
      check($sformatf("fwd_addr@%h", a), seen_addr, (k == 1) ? a : a - 32'h4000_0000);
      check($sformatf("fwd_wdata@%h", a), seen_wdata, wd);
      check($sformatf("fwd_wstrb@%h", a), 32'(seen_wstrb), 32'(st));
      check($sformatf("fwd_instr@%h", a), 32'(seen_instr), 32'(ins));
    end
  endtask

  task automatic zero_checks(input string ph);
    check({ph, "_cpu_ready"}, 32'(cpu_mem_ready), 32'd0);
    check({ph, "_cpu_rdata"}, cpu_mem_rdata, 32'd0);
    check({ph, "_bus_err"}, 32'(bus_err), 32'd0);
    check({ph, "_bus_err_addr"}, bus_err_addr, 32'd0);
    check({ph, "_ram_valid"}, 32'(ram_mem_valid), 32'd0);
    check({ph, "_mmio_valid"}, 32'(mmio_mem_valid), 32'd0);
    check({ph, "_ram_addr"}, ram_mem_addr, 32'd0);
    check({ph, "_mmio_addr"}, mmio_mem_addr, 32'd0);
    check({ph, "_ram_wdata"}, ram_mem_wdata, 32'd0);
    check({ph, "_strobes"}, 32'({ram_mem_wstrb, mmio_mem_wstrb}), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, a;
    logic er;
    int cyc, kind;
    for (int i = 0; i < 2048; i++) begin ram_mem[i] = $urandom; ref_ram[i] = ram_mem[i]; end
    for (int i = 0; i < 64; i++) begin mmio_regs[i] = $urandom; ref_mmio[i] = mmio_regs[i]; end
    repeat (2) @(negedge clk);
    zero_checks("reset");
    resetn = 1'b1;

    ram_mem[4] = 32'h1234_5678; ref_ram[4] = 32'h1234_5678;
    run(32'h0000_0010, 32'h0, 4'b0000, 1'b1, 1'b0, 1);
    run(32'h0000_1004, 32'hAABB_CCDD, 4'b0011, 1'b0, 1'b0, 0);
    check("bram_low_half", 32'(ram_mem[11'h401][15:0]), 32'h0000_CCDD);
    run(32'h0000_1004, 32'h0, 4'b0000, 1'b0, 1'b1, 2);
    mmio_regs[2] = 32'hCAFE_0001; ref_mmio[2] = 32'hCAFE_0001;
    run(32'h4000_0008, 32'h0, 4'b0000, 1'b0, 1'b0, 3);
    run(32'h8000_0000, 32'h0, 4'b0000, 1'b0, 1'b1, 0);
    run(32'h0001_0010, 32'h5555_AAAA, 4'b1111, 1'b0, 1'b0, 0);
    run(32'h4000_0100, 32'h0, 4'b0000, 1'b0, 1'b0, 0);

`ifdef MEM_BUS_TIMEOUT_EN
    mmio_lat = 50;
    access(32'h4000_0004, 32'h0, 4'b0000, 1'b0, 1'b0, rd, er, cyc);
    check("to_rdata", rd, ERR);
    check("to_bus_err", 32'(er), 32'd1);
    check("to_valid_cycles", mmio_vcyc, TO);
    check("to_latency", cyc, TO + 1);
    check("to_err_addr", bus_err_addr, 32'h4000_0004);
    run(32'h4000_000C, $urandom, 4'b0000, 1'b0, 1'b0, TO - 1);
`else
    run(32'h4000_000C, $urandom, 4'b0000, 1'b0, 1'b0, 300);
`endif

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0, 1: a = {19'd0, 11'($urandom), 2'b00};
        2: a = 32'h4000_0000 + {24'd0, 6'($urandom), 2'b00};
        3: a = {1'b1, 29'($urandom), 2'b00};
        default: a = 32'h0000_2000 + {28'd0, 2'($urandom), 2'b00};
      endcase
      run(a, $urandom, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000,
          1'($urandom), 1'($urandom), $urandom_range(0, 4));
    end

    ram_stall = 1'b1;
    @(negedge clk);
    cpu_mem_valid = 1'b1; cpu_mem_addr = 32'h0000_0020; cpu_mem_wstrb = 4'b0000;
    cpu_mem_wdata = 32'h1357_9BDF;
    @(negedge clk);
    check("stall_ram_valid", 32'(ram_mem_valid), 32'd1);
    #2 resetn = 1'b0;
    #1 zero_checks("mid_reset");
    cpu_mem_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1; ram_stall = 1'b0;
    run(32'h0000_0000, 32'h0, 4'b0000, 1'b0, 1'b0, 1);

    check("bus_rule_violations", bus_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_bus_router.md
Name: mem_bus_router

Overview:
- Sits between the PicoRV32 native memory port and its slaves: the unified BRAM (instructions + data) and the AES co-processor MMIO window.
- Registers each CPU request and decodes the address to one slave, or to an error response.
- Runs the slave handshake and returns a registered response to the CPU.
- Unmapped accesses and (optionally) hung slaves get a deterministic error response instead of stalling the core.

Parameters:
- RAM_BYTES, 8192: size of the RAM window starting at 0x0000_0000; must be a power of two.
- MMIO_BASE, 32'h4000_0000: base of the MMIO window.
- MMIO_BYTES, 256: size of the MMIO window; must be a power of two; MMIO_BASE must be aligned to it.
- TIMEOUT_CYCLES, 255: slave wait limit, used only when the timeout feature is compiled in; range 1..65535.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on any error response.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset; one clock, reset asynchronous active-low.
- cpu_mem_valid  in  1  CPU request valid.
- cpu_mem_instr  in  1  instruction fetch flag.
- cpu_mem_ready  out  1  one-cycle response strobe to the CPU.
- cpu_mem_addr  in  32  byte address.
- cpu_mem_wdata  in  32  write data.
- cpu_mem_wstrb  in  4  byte enables; 0 means read.
- cpu_mem_rdata  out  32  registered read data.
- ram_mem_valid / mmio_mem_valid  out  1  slave request.
- ram_mem_instr / mmio_mem_instr  out  1  forwarded fetch flag.
- ram_mem_addr / mmio_mem_addr  out  32  forwarded address; MMIO address is the offset from MMIO_BASE.
- ram_mem_wdata / mmio_mem_wdata  out  32  forwarded write data.
- ram_mem_wstrb / mmio_mem_wstrb  out  4  forwarded byte enables.
- ram_mem_ready / mmio_mem_ready  in  1  slave done.
- ram_mem_rdata / mmio_mem_rdata  in  32  slave read data.
- bus_err  out  1  one-cycle pulse on any error response.
- bus_err_addr  out  32  address of the most recent error; holds its value until the next error.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - State goes to IDLE.
  - All valid, ready and bus_err outputs go to 0.
  - All address, data, strobe and rdata outputs go to 0.
  - No pending slave request survives reset.
- States: IDLE, RAM_WAIT, MMIO_WAIT, RESP.
- IDLE, when cpu_mem_valid=1 and cpu_mem_ready=0:
  - Capture instr, addr, wdata and wstrb.
  - Decode on the captured address:
    - addr < RAM_BYTES → RAM_WAIT.
    - MMIO_BASE <= addr < MMIO_BASE+MMIO_BYTES → MMIO_WAIT.
    - Otherwise → RESP with error.
  - The selected slave's valid is asserted from the next cycle, driven from registers only; there is no combinational path from cpu_* to slave ports.
- RAM_WAIT / MMIO_WAIT:
  - Hold the slave valid and all request fields stable until the slave's ready=1.
  - On that edge: deassert valid, latch the slave's rdata into cpu_mem_rdata, go to RESP.
  - The ready of the non-selected slave is ignored.
- RESP:
  - cpu_mem_ready=1 for exactly one cycle, then IDLE.
  - cpu_mem_valid is ignored during RESP, so a held valid cannot start a duplicate transaction; a new request is accepted no earlier than the cycle after RESP.
- Error response (unmapped address or timeout):
  - cpu_mem_rdata=ERR_RDATA for reads and writes alike.
  - bus_err=1 in the RESP cycle.
  - bus_err_addr=captured address.
  - No slave is touched for unmapped addresses.
- Latency: the router adds 2 cycles (request register plus response register) on top of the slave's latency. Unmapped address: cpu_mem_ready is seen 2 cycles after the request is accepted in IDLE.
- Writes: cpu_mem_rdata is updated with the slave's rdata anyway; the CPU ignores it.
- Width rules:
  - RAM address passes through unchanged.
  - MMIO address = addr − MMIO_BASE, zero-extended.
  - Window compares use the full 32-bit address, so high-address aliases do not hit.
- Idle slave outputs: a slave that is not being accessed sees valid=0. Its addr/wdata/wstrb fields are don't-care, but wstrb must be 0 whenever valid=0.

Optional Feature:
- Macro: MEM_BUS_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to RAM_WAIT/MMIO_WAIT and increments each waiting cycle.
  - When the count reaches TIMEOUT_CYCLES without a slave ready: drop the slave valid and go to RESP with an error response.
  - A slave ready arriving in the same cycle as the limit wins; that is a normal response.
- Undefined: no counter logic exists and the router waits indefinitely for the slave's ready.

Test Plan:
- Read 0x0000_0010 with BRAM word 4 = 0x1234_5678 → ram_mem_addr=0x10, cpu_mem_rdata=0x1234_5678, one-cycle cpu_mem_ready, bus_err=0.
- Write 0x0000_1004, wdata=0xAABB_CCDD, wstrb=4'b0011 → BRAM word 0x401 low half = 0xCCDD, upper half unchanged; subsequent read returns the merged word.
- Read 0x4000_0008, MMIO model returns 0xCAFE_0001 after 3 cycles → mmio_mem_addr=0x8, cpu_mem_rdata=0xCAFE_0001, ram_mem_valid never 1.
- Read 0x8000_0000 → cpu_mem_ready 2 cycles after the request is accepted, rdata=0xDEAD_BEEF, bus_err pulse, bus_err_addr=0x8000_0000, no slave valid.
- With MEM_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, MMIO never ready → mmio_mem_valid drops after 8 waiting cycles, rdata=0xDEAD_BEEF, bus_err=1.
- Assert resetn=0 while in RAM_WAIT → all outputs 0 immediately (before the next clk edge); after release, a new read of 0x0 completes normally.
